// File: rtl/edge_event_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arb_if
// Purpose  : Event stream between edge_event_arb (source) and its consumer.
//            The source presents one edge event per transfer; a transfer
//            completes on a clock where evt_valid and evt_ready are both 1.
// Signals  : evt_valid   - event presented on evt_chan/evt_is_fall
//            evt_ready   - consumer accepts the presented event
//            evt_chan    - channel index of the presented event
//            evt_is_fall - 0 = rising edge, 1 = falling edge
// Modports : master (event source), slave (event consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface edge_event_arb_if #(
    parameter int NCH = 4
);
    localparam int c_CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             evt_valid;
    logic             evt_ready;
    logic [c_CHW-1:0] evt_chan;
    logic             evt_is_fall;

    modport master (
        output evt_valid,
        output evt_chan,
        output evt_is_fall,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_chan,
        input  evt_is_fall,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/edge_event_arb.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arb
// Purpose  : Detects rising (and optionally falling) edges on NCH level
//            inputs, latches them as per-channel pending flags and presents
//            them one at a time on a valid/ready event stream using
//            round-robin arbitration across channels. Edges arriving while
//            the matching flag is still pending are dropped and flagged in
//            a sticky per-channel overflow vector.
// Ports    : clk      - clock, all state on rising edge
//            reset    - synchronous active-high reset
//            a_in     - [NCH] monitored level inputs (synchronous to clk)
//            ovf_clr  - clears all overflow flags
//            ovf      - [NCH] sticky event-lost flags
//            evt      - event stream (edge_event_arb_if.master)
// Config   : EDGE_ARB_FE_EN - when defined, falling edges are captured and
//            arbitrated as well; otherwise only rising edges are reported
//            and evt_is_fall is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module edge_event_arb #(
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   a_in,
    input  logic             ovf_clr,
    output logic [NCH-1:0]   ovf,
    edge_event_arb_if.master evt
);

    localparam int c_CHW = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef EDGE_ARB_FE_EN
    localparam logic c_FE_EN = 1'b1;
`else
    localparam logic c_FE_EN = 1'b0;
`endif

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_PRESENT = 1'b1;

    logic [NCH-1:0]   r_a_q;
    logic [NCH-1:0]   r_re_pend;
    logic [NCH-1:0]   r_ovf;
    logic [0:0]       r_state;
    logic             r_evt_valid;
    logic [c_CHW-1:0] r_evt_chan;
    logic             r_evt_is_fall;
    logic [c_CHW-1:0] r_last_grant;

    logic [NCH-1:0]   w_rise;
    logic [NCH-1:0]   w_fall;
    logic [NCH-1:0]   w_fe_pend;
    logic [NCH-1:0]   w_any_ch;
    logic [NCH-1:0]   w_re_clr;
    logic [NCH-1:0]   w_fe_clr;
    logic [NCH-1:0]   w_ovf_set;
    logic [0:0]       w_state_nxt;
    logic             w_valid_nxt;
    logic [c_CHW-1:0] w_chan_nxt;
    logic             w_is_fall_nxt;
    logic [c_CHW-1:0] w_gnt_idx;
    logic [c_CHW-1:0] w_cand;
    logic             w_found;
    logic             w_gnt_is_fall;
    logic             w_load;

    // ------------------------------------------------------------------
    // Edge detection and falling-edge pending flags
    // ------------------------------------------------------------------
    assign w_rise = a_in & ~r_a_q;

`ifdef EDGE_ARB_FE_EN
    logic [NCH-1:0] r_fe_pend;

    assign w_fall    = ~a_in & r_a_q;
    assign w_fe_pend = r_fe_pend;

    // A newly detected edge wins over the grant clear of the same flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fe_pend <= '0;
        end else begin
            r_fe_pend <= (r_fe_pend & ~w_fe_clr) | w_fall;
        end
    end
`else
    assign w_fall    = '0;
    assign w_fe_pend = '0;
`endif

    assign w_any_ch = r_re_pend | w_fe_pend;

    // An edge is lost only when its flag is still pending after this
    // cycle's grant clear has been taken into account.
    assign w_ovf_set = (w_rise & r_re_pend & ~w_re_clr)
                     | (w_fall & w_fe_pend & ~w_fe_clr);

    // ------------------------------------------------------------------
    // Round-robin search starting one past the last granted channel.
    // The cast wraps modulo NCH since NCH is a power of two; the final
    // iteration revisits last_grant itself.
    // ------------------------------------------------------------------
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = 1; i <= NCH; i++) begin
            w_cand = r_last_grant + c_CHW'(i);
            if (!w_found && w_any_ch[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        // Rising edge is presented first when both are pending.
        w_gnt_is_fall = c_FE_EN & ~r_re_pend[w_gnt_idx];
    end

    // ------------------------------------------------------------------
    // Presentation FSM: next state, next registered outputs, grant clears
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = r_evt_valid;
        w_chan_nxt    = r_evt_chan;
        w_is_fall_nxt = r_evt_is_fall;
        w_load        = 1'b0;
        w_re_clr      = '0;
        w_fe_clr      = '0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_PRESENT;
                end
            end
            c_ST_PRESENT: begin
                if (r_evt_valid && evt.evt_ready) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_valid_nxt   = 1'b1;
            w_chan_nxt    = w_gnt_idx;
            w_is_fall_nxt = w_gnt_is_fall;
            if (w_gnt_is_fall) begin
                w_fe_clr[w_gnt_idx] = 1'b1;
            end else begin
                w_re_clr[w_gnt_idx] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // Track the input during reset so a level held across reset
        // release is not seen as an edge.
        r_a_q <= a_in;
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_evt_valid   <= 1'b0;
            r_evt_chan    <= '0;
            r_evt_is_fall <= 1'b0;
            r_re_pend     <= '0;
            r_ovf         <= '0;
            r_last_grant  <= c_CHW'(NCH - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_evt_valid   <= w_valid_nxt;
            r_evt_chan    <= w_chan_nxt;
            r_evt_is_fall <= w_is_fall_nxt;
            r_re_pend     <= (r_re_pend & ~w_re_clr) | w_rise;
            r_ovf         <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
            if (w_load) begin
                r_last_grant <= w_gnt_idx;
            end
        end
    end

    assign evt.evt_valid   = r_evt_valid;
    assign evt.evt_chan    = r_evt_chan;
    assign evt.evt_is_fall = r_evt_is_fall;
    assign ovf             = r_ovf;

endmodule
`default_nettype wire
